// File: rtl/button_bank.sv
// Bank of independent push-button channels: two-flop synchronizer, debounce,
// press/release edge pulses, long-press detection and auto-repeat per channel.
module button_bank #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_in,
  input  logic [N_BTN-1:0]   repeat_en,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   press_pulse,
  output logic [N_BTN-1:0]   release_pulse,
  output logic [N_BTN-1:0]   long_pulse,
  output logic [N_BTN-1:0]   repeat_pulse,
  output logic               any_press,
  output logic [2*N_BTN-1:0] dbg_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             any_press_q, any_press_d;

  logic [DW-1:0] deb_cnt_q  [N_BTN];
  logic [DW-1:0] deb_cnt_d  [N_BTN];
  logic [HW-1:0] hold_cnt_q [N_BTN];
  logic [HW-1:0] hold_cnt_d [N_BTN];
  logic [RW-1:0] rep_cnt_q  [N_BTN];
  logic [RW-1:0] rep_cnt_d  [N_BTN];
  state_e        state_q    [N_BTN];
  state_e        state_d    [N_BTN];

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_cnt_d[i]  = rep_cnt_q[i];
      state_d[i]    = state_q[i];

      // Debounce: a mismatch must survive DEBOUNCE_CYCLES consecutive edges.
      if (sync2_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        level_d[i]   = ~level_q[i];
        press_d[i]   = ~level_q[i];
        release_d[i] = level_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
      end

      if (!level_q[i] || press_d[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_MAX) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
      end

      case (state_q[i])
        ST_IDLE: begin
          rep_cnt_d[i] = '0;
          if (press_d[i]) state_d[i] = ST_HELD;
        end
        ST_HELD: begin
          if (release_d[i]) begin
            state_d[i] = ST_IDLE;
          end else if (hold_cnt_q[i] == HOLD_LAST) begin
            long_d[i]    = 1'b1;
            rep_cnt_d[i] = '0;
            state_d[i]   = ST_LONG;
          end
        end
        ST_LONG: begin
          // Dropping repeat_en restarts the full period on re-enable.
          if (release_d[i]) begin
            rep_cnt_d[i] = '0;
            state_d[i]   = ST_IDLE;
          end else if (!repeat_en[i]) begin
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == REP_LAST) begin
            rep_cnt_d[i] = '0;
            repeat_d[i]  = 1'b1;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + REP_ONE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
        state_q[i]    <= ST_IDLE;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_cnt_q[i]  <= rep_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign any_press     = any_press_q;

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed timing scenarios plus randomized button
// activity, all checked cycle by cycle against a timestamp-based model.
module tb_button_bank;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   btn_in;
  logic [N-1:0]   repeat_en;
  logic [N-1:0]   btn_level;
  logic [N-1:0]   press_pulse;
  logic [N-1:0]   release_pulse;
  logic [N-1:0]   long_pulse;
  logic [N-1:0]   repeat_pulse;
  logic           any_press;
  logic [2*N-1:0] dbg_state;

  button_bank #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .any_press(any_press), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronizer as a 2-deep delay line; debounce as "D consecutive
  // mismatching samples"; long/repeat from press and period timestamps.
  logic [N-1:0] m_s1, m_s2, m_level;
  int           m_run       [N];
  int           m_press_cyc [N];
  bit           m_in_long   [N];
  int           m_rep_start [N];
  logic [N-1:0] e_press, e_release, e_long, e_repeat;
  logic         e_any;

  task automatic model_step();
    logic [N-1:0] new_s1, new_s2;
    bit prs, rel;
    e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; e_any = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_press_cyc[c] = -1; m_in_long[c] = 0; m_rep_start[c] = 0;
      end
      return;
    end
    new_s1 = btn_in;
    new_s2 = m_s1;
    for (int c = 0; c < N; c++) begin
      prs = 0; rel = 0;
      if (m_s2[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_run[c] = 0;
          if (m_level[c]) rel = 1; else prs = 1;
        end
      end else begin
        m_run[c] = 0;
      end
      if (prs) begin
        e_press[c] = 1'b1; m_press_cyc[c] = cyc; m_in_long[c] = 0; m_level[c] = 1'b1;
      end else if (rel) begin
        e_release[c] = 1'b1; m_press_cyc[c] = -1; m_in_long[c] = 0; m_level[c] = 1'b0;
      end else if (m_press_cyc[c] >= 0) begin
        if (!m_in_long[c] && cyc == m_press_cyc[c] + L) begin
          e_long[c] = 1'b1; m_in_long[c] = 1; m_rep_start[c] = cyc;
        end else if (m_in_long[c]) begin
          if (!repeat_en[c]) m_rep_start[c] = cyc;
          else if (cyc - m_rep_start[c] == R) begin
            e_repeat[c] = 1'b1; m_rep_start[c] = cyc;
          end
        end
      end
    end
    m_s1 = new_s1;
    m_s2 = new_s2;
    e_any = |e_press;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_eq("btn_level", 32'(btn_level), 32'(m_level));
    check_eq("press", 32'(press_pulse), 32'(e_press));
    check_eq("release", 32'(release_pulse), 32'(e_release));
    check_eq("long", 32'(long_pulse), 32'(e_long));
    check_eq("repeat", 32'(repeat_pulse), 32'(e_repeat));
    check_eq("any_press", 32'(any_press), 32'(e_any));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- scenarios ----------------
  int n, any_cnt, long_cnt, late_pulses;
  int t_press, t_long;
  int rep_q[$];
  bit saw_press;
  int hold_left [N];

  initial begin
    reset = 1'b1; btn_in = '0; repeat_en = '0;
    ticks(2);
    check_eq("reset_level", 32'(btn_level), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    ticks(3);

    // Single press: accepted on the 6th edge with any_press alongside.
    btn_in = 4'b0001; n = 0;
    do begin tick(); n++; end while (!press_pulse[0] && n < 12);
    check_eq("press_latency", 32'(n), 32'd6);
    check_eq("press_level0", 32'(btn_level[0]), 32'd1);
    check_eq("press_any0", 32'(any_press), 32'd1);
    tick();
    check_eq("press_one_cycle", 32'(press_pulse[0]), 32'd0);
    btn_in = 4'b0000;
    ticks(10);

    // Short glitch is discarded.
    btn_in = 4'b0010; saw_press = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (press_pulse[1]) saw_press = 1; end
    btn_in = 4'b0000;
    for (int k = 0; k < 10; k++) begin tick(); if (press_pulse[1] || btn_level[1]) saw_press = 1; end
    check_eq("glitch_ignored", 32'(saw_press), 32'd0);

    // Simultaneous press on channels 0 and 3.
    btn_in = 4'b1001; n = 0; any_cnt = 0;
    do begin tick(); n++; end while (press_pulse == '0 && n < 12);
    check_eq("simul_press", 32'(press_pulse), 32'b1001);
    if (any_press) any_cnt++;
    for (int k = 0; k < 10; k++) begin tick(); if (any_press) any_cnt++; end
    check_eq("simul_any_once", 32'(any_cnt), 32'd1);
    btn_in = 4'b0000;
    ticks(10);

    // Long press with auto-repeat on channel 2, then release.
    repeat_en = 4'b0100; btn_in = 4'b0100;
    t_press = -1; t_long = -1; long_cnt = 0; late_pulses = 0; rep_q.delete();
    for (int k = 0; k < 50; k++) begin
      tick();
      if (press_pulse[2]) t_press = cyc;
      if (long_pulse[2]) begin t_long = cyc; long_cnt++; end
      if (repeat_pulse[2]) rep_q.push_back(cyc);
    end
    btn_in = 4'b0000; n = 0;
    do begin
      tick(); n++;
      if (repeat_pulse[2]) rep_q.push_back(cyc);
    end while (!release_pulse[2] && n < 20);
    check_eq("long_release_seen", 32'(release_pulse[2]), 32'd1);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (long_pulse[2] || repeat_pulse[2]) late_pulses++;
    end
    check_eq("long_after_press", 32'(t_long - t_press), 32'(L));
    check_eq("long_once", 32'(long_cnt), 32'd1);
    check_eq("rep_count_ge2", 32'(rep_q.size() >= 2), 32'd1);
    if (rep_q.size() >= 2) begin
      check_eq("rep1_offset", 32'(rep_q[0] - t_long), 32'(R));
      check_eq("rep2_offset", 32'(rep_q[1] - t_long), 32'(2 * R));
    end
    check_eq("no_pulse_after_release", 32'(late_pulses), 32'd0);

    // Reset during LONG with button held: re-qualifies through debounce.
    btn_in = 4'b0100;
    ticks(30);
    check_eq("in_long_state", 32'(dbg_state[5:4]), 32'd2);
    reset = 1'b1;
    tick();
    check_eq("rst_outputs",
             32'({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press}),
             32'd0);
    check_eq("rst_fsm_idle", 32'(dbg_state), 32'd0);
    reset = 1'b0; n = 0;
    do begin tick(); n++; end while (!press_pulse[2] && n < 12);
    check_eq("press_after_reset", 32'(n), 32'd6);
    btn_in = 4'b0000; repeat_en = '0;
    ticks(12);

    // Randomized activity on all channels.
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          hold_left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(8, 80);
        end
        hold_left[c]--;
        if ($urandom_range(0, 40) == 0) repeat_en[c] = ~repeat_en[c];
      end
      reset = ($urandom_range(0, 700) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a changed level must persist before acceptance (>=1).
REQ-003 SHALL have parameter LONG_CYCLES, default 1000: cycles a press must be held before a long-press event (>=2).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 250: auto-repeat period after a long-press (>=1).
REQ-005 SHALL have port clk, input, 1 bit: system clock; the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port btn_in, input, N_BTN bits: raw asynchronous button levels, active-high.
REQ-008 SHALL have port repeat_en, input, N_BTN bits: per-channel auto-repeat enable.
REQ-009 SHALL have port btn_level, output, N_BTN bits: debounced level per channel.
REQ-010 SHALL have port press_pulse, output, N_BTN bits: one-cycle pulse on accepted 0->1.
REQ-011 SHALL have port release_pulse, output, N_BTN bits: one-cycle pulse on accepted 1->0.
REQ-012 SHALL have port long_pulse, output, N_BTN bits: one-cycle pulse at long-press threshold.
REQ-013 SHALL have port repeat_pulse, output, N_BTN bits: one-cycle auto-repeat pulses.
REQ-014 SHALL have port any_press, output, 1 bit: registered OR of press_pulse across channels, same cycle as press_pulse.

Function
REQ-015 SHALL pass each btn_in bit through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-016 SHALL keep per channel a debounce counter of width $clog2(DEBOUNCE_CYCLES+1); cleared whenever sync2 equals btn_level.
REQ-017 SHALL, while sync2 differs from btn_level, increment the counter; on the edge where counter == DEBOUNCE_CYCLES-1 and mismatch persists, toggle btn_level and clear the counter.
REQ-018 SHALL therefore update btn_level on the (DEBOUNCE_CYCLES+2)th rising edge counting the first edge that samples the new btn_in level, provided btn_in holds throughout.
REQ-019 SHALL discard any glitch returning to the btn_level value before the threshold (counter cleared, no output change).
REQ-020 SHALL assert press_pulse/release_pulse for exactly one cycle, registered on the same edge as the btn_level toggle.
REQ-021 SHALL keep per channel a hold counter of width $clog2(LONG_CYCLES+1), cleared when btn_level is 0 and on the press edge, incrementing each cycle btn_level is 1, saturating at LONG_CYCLES.
REQ-022 SHALL assert long_pulse for one cycle exactly LONG_CYCLES cycles after that channel's press_pulse cycle, once per press.
REQ-023 SHALL, per channel, run a state machine IDLE -> HELD (press) -> LONG (long_pulse) -> IDLE (release from any state).
REQ-024 SHALL, in LONG with repeat_en=1, assert repeat_pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after long_pulse; period counter cleared on entering LONG.
REQ-025 SHALL, when repeat_en drops in LONG, suppress repeat_pulse immediately and clear the period counter; re-enabling restarts a full period.
REQ-026 SHALL suppress long_pulse and repeat_pulse in the release_pulse cycle and thereafter until the next press.
REQ-027 SHALL keep channels fully independent; simultaneous events on multiple channels all reported in the same cycle.

Reset
REQ-028 SHALL, on reset high at a clock edge, clear sync flops, all counters, btn_level, all pulse outputs, any_press, and return every FSM to IDLE.
REQ-029 SHALL, if reset occurs mid-press, require btn_in to re-qualify through full debounce; a button held across reset produces press_pulse DEBOUNCE_CYCLES+2 edges after reset release.

Verification
REQ-030 SHALL cover (N_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8): btn_in[0] 0->1 held -> btn_level[0]=1 and press_pulse[0]=1 for one cycle on 6th edge, any_press same cycle.
REQ-031 SHALL cover: btn_in[1] high 3 cycles then low -> no press_pulse, btn_level[1] stays 0.
REQ-032 SHALL cover: btn_in[2] held 50 cycles, repeat_en[2]=1 -> long_pulse 20 cycles after press_pulse, repeat_pulse at +8 and +16 after long_pulse, release_pulse after release with no further pulses.
REQ-033 SHALL cover: btn_in[0] and btn_in[3] rise on same edge -> press_pulse=4'b1001 in one cycle, any_press=1 once.
REQ-034 SHALL cover: reset asserted for 1 cycle during LONG on channel 2 with btn_in held -> all outputs 0 next cycle; press_pulse[2] reappears 6 edges after reset deasserts.
